ps2_rx: RTL and testbench
=========================

PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal ps2c samples required to change the filtered PS/2 clock level.
REQ-002 Parameter TIMEOUT, default 100000: maximum clk cycles allowed between PS/2 clock falling edges inside a frame; legal range 2..131071 (17-bit counter).
REQ-003 clk  input  1  system clock; all logic is in this single clock domain.
REQ-004 rst  input  1  reset, asynchronous and active-low; all state is cleared while rst=0.
REQ-005 ps2c  input  1  PS/2 clock line from the keyboard, asynchronous to clk.
REQ-006 ps2d  input  1  PS/2 data line from the keyboard, asynchronous to clk.
REQ-007 rx_en  input  1  receive enable; gates only the acceptance of a start bit.
REQ-008 dout  output  8  last correctly received scan-code byte.
REQ-009 rx_done  output  1  one-cycle pulse marking a valid byte; drives act_0 of the downstream control FSM.
REQ-010 parity_err  output  1  one-cycle pulse: frame discarded for odd-parity failure.
REQ-011 frame_err  output  1  one-cycle pulse: frame discarded for stop bit = 0 or inter-edge timeout.
REQ-012 busy  output  1  high while state is not IDLE.

Function
REQ-013 ps2c and ps2d SHALL each pass through a two-flop synchronizer before any other use.
REQ-014 Filter: the filtered clock SHALL go 1 after FILTER_LEN consecutive synced-1 samples, go 0 after FILTER_LEN consecutive synced-0 samples, and otherwise hold its value.
REQ-015 fall_edge SHALL be a one-cycle internal pulse generated when the filtered clock changes 1->0.
REQ-016 The FSM SHALL have three states: IDLE, RECV and CHECK.
REQ-017 IDLE: on fall_edge with rx_en=1 and synced ps2d=0, go to RECV, load bit counter=10 and clear the timeout counter.
REQ-018 IDLE: fall_edge with ps2d=1 or rx_en=0 SHALL be ignored, with no error pulse.
REQ-019 RECV: each fall_edge SHALL shift synced ps2d into the MSB of a 10-bit shift register (shift right, LSB-first framing), decrement the bit counter and clear the timeout counter.
REQ-020 RECV: the fall_edge that decrements the bit counter from 1 to 0 SHALL move the FSM to CHECK; the register then holds data[7:0], parity in bit 8 and stop in bit 9.
REQ-021 RECV: if the timeout counter reaches TIMEOUT-1 with no fall_edge, the FSM SHALL return to IDLE and pulse frame_err once.
REQ-022 CHECK SHALL last exactly one cycle and SHALL always return to IDLE.
REQ-023 CHECK, stop=1 and XOR of the 9 data+parity bits = 1: dout SHALL load data and rx_done SHALL pulse in the following cycle.
REQ-024 CHECK, stop=0: frame_err SHALL pulse, and parity SHALL not be evaluated.
REQ-025 CHECK, stop=1 and parity failure: parity_err SHALL pulse.
REQ-026 On any error, dout SHALL keep its previous value and rx_done SHALL stay low.
REQ-027 rx_done, parity_err and frame_err SHALL be registered, mutually exclusive and never high for more than one consecutive cycle.
REQ-028 Latency: rx_done SHALL rise exactly 2 clk cycles after the fall_edge pulse of the stop bit.
REQ-029 dout SHALL remain stable from one rx_done pulse until the next rx_done pulse.
REQ-030 Deasserting rx_en in RECV or CHECK SHALL NOT abort the frame in progress.
REQ-031 busy SHALL be high in RECV and CHECK and low in IDLE.

Reset
REQ-032 While rst=0: state=IDLE, dout=8'h00, rx_done=parity_err=frame_err=busy=0, shift register=0, bit and timeout counters=0, synchronizers and filter history all 1, filtered clock=1.
REQ-033 Assertion of rst mid-frame SHALL discard the frame without any pulse, and the first frame after release SHALL be received normally.

Verification
REQ-034 Frame 0x1C: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1 -> dout=8'h1C, one rx_done pulse 2 cycles after the stop edge, no error pulses.
REQ-035 After 0x1C, send 0xF0 with parity 0 (wrong) -> one parity_err pulse, dout stays 8'h1C, no rx_done.
REQ-036 0x1C with stop bit 0 -> one frame_err pulse, dout unchanged, busy returns to 0.
REQ-037 Halt ps2c after 5 bits for more than TIMEOUT cycles -> one frame_err pulse, FSM in IDLE; the next full 0x1C frame gives dout=8'h1C with rx_done.
REQ-038 ps2c low glitch of FILTER_LEN-2 cycles while IDLE and while in RECV -> no bit sampled, bit counter unchanged, no pulses.
REQ-039 rst=0 pulse after bit 4 of a frame -> all outputs at reset values, no pulses; the following 0xF0 frame with parity 1 -> dout=8'hF0 with rx_done.

Source files
------------

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 clock, frames
// 11-bit start/data/parity/stop words and reports good bytes or discarded frames.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] dout,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RECV  = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [16:0] TO_LAST = 17'(TIMEOUT - 1);

    // Odd parity over data plus parity bit: a good frame has an odd count of ones.
    function automatic logic parity_ok(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic                  ps2c_p0, ps2c_p1;
    logic                  ps2d_p0, ps2d_p1;
    logic [FILTER_LEN-1:0] filt_hist_p2;
    logic                  filt_clk_p3;
    logic                  filt_clk_p4;
    logic                  fall_edge;

    logic [1:0]            state;
    logic [9:0]            shreg;
    logic [3:0]            bit_cnt;
    logic [16:0]           to_cnt;

    // Stage p0/p1: two-flop synchronisers, idle-high after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps2c_p0 <= 1'b1;
            ps2c_p1 <= 1'b1;
            ps2d_p0 <= 1'b1;
            ps2d_p1 <= 1'b1;
        end else begin
            ps2c_p0 <= ps2c;
            ps2c_p1 <= ps2c_p0;
            ps2d_p0 <= ps2d;
            ps2d_p1 <= ps2d_p0;
        end
    end

    // Stage p2/p3: the filtered clock only moves once the whole history agrees
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_hist_p2 <= '1;
            filt_clk_p3  <= 1'b1;
            filt_clk_p4  <= 1'b1;
        end else begin
            filt_hist_p2 <= {filt_hist_p2[FILTER_LEN-2:0], ps2c_p1};
            if (&filt_hist_p2) begin
                filt_clk_p3 <= 1'b1;
            end else if (~|filt_hist_p2) begin
                filt_clk_p3 <= 1'b0;
            end
            filt_clk_p4 <= filt_clk_p3;
        end
    end

    assign fall_edge = filt_clk_p4 & ~filt_clk_p3;

    // Frame FSM; status pulses are registered so they appear one cycle after CHECK
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            dout       <= 8'h00;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall_edge && rx_en && !ps2d_p1) begin
                        state   <= RECV;
                        bit_cnt <= 4'd10;
                        to_cnt  <= '0;
                    end
                end
                RECV: begin
                    if (fall_edge) begin
                        shreg   <= {ps2d_p1, shreg[9:1]};
                        bit_cnt <= bit_cnt - 4'd1;
                        to_cnt  <= '0;
                        if (bit_cnt == 4'd1) begin
                            state <= CHECK;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                        to_cnt    <= '0;
                    end else begin
                        to_cnt <= to_cnt + 17'd1;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    if (!shreg[9]) begin
                        frame_err <= 1'b1;
                    end else if (parity_ok(shreg[8:0])) begin
                        dout    <= shreg[7:0];
                        rx_done <= 1'b1;
                    end else begin
                        parity_err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed and randomized frame tests for ps2_rx against an outcome-level
// model: each frame is predicted as good byte, parity error, frame error or ignored.
module tb_ps2_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 200;
    localparam int HALF       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       rx_en = 1'b1;
    logic [7:0] dout;
    logic       rx_done, parity_err, frame_err, busy;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .dout(dout), .rx_done(rx_done), .parity_err(parity_err),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Pulse monitor, sampled on the inactive edge
    int         cyc = 0, last_fe = -100;
    int         n_done = 0, n_perr = 0, n_ferr = 0;
    int         lat_bad = 0, excl_bad = 0, dout_bad = 0;
    logic       prev_any = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    always @(negedge clk) begin
        int n_hi;
        cyc = cyc + 1;
        if (dut.fall_edge) last_fe = cyc;
        n_hi = int'(rx_done) + int'(parity_err) + int'(frame_err);
        if (rx_done) begin
            n_done = n_done + 1;
            if (cyc - last_fe != 2) lat_bad = lat_bad + 1;
        end
        if (parity_err) n_perr = n_perr + 1;
        if (frame_err) n_ferr = n_ferr + 1;
        if (n_hi > 1 || (n_hi > 0 && prev_any)) excl_bad = excl_bad + 1;
        prev_any = (n_hi > 0);
        if (rst && !rx_done && dout !== prev_dout) dout_bad = dout_bad + 1;
        prev_dout = dout;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive frame bits lo..hi (bit 0 = start); data is set while the clock is high
    task automatic send_bits(input logic [10:0] bits, input int lo, input int hi,
                             input bit drop_en);
        for (int i = lo; i <= hi; i++) begin
            ps2d = bits[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
            if (i == 0 && drop_en) rx_en = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ps2d = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] data, input logic par,
                                             input logic stop);
        return {stop, par, data, 1'b0};
    endfunction

    task automatic glitch();
        @(negedge clk);
        ps2c = 1'b0;
        repeat (FILTER_LEN - 2) @(negedge clk);
        ps2c = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    logic [7:0] exp_dout = 8'h00;
    int         d0, p0, f0;

    task automatic snap();
        d0 = n_done; p0 = n_perr; f0 = n_ferr;
    endtask

    // Expected outcome: 0 ignored, 1 good byte, 2 parity error, 3 frame error
    task automatic expect_outcome(input string tag, input int kind);
        repeat (10) @(negedge clk);
        check({tag, ".rx_done"}, n_done - d0, (kind == 1) ? 1 : 0);
        check({tag, ".parity_err"}, n_perr - p0, (kind == 2) ? 1 : 0);
        check({tag, ".frame_err"}, n_ferr - f0, (kind == 3) ? 1 : 0);
        check({tag, ".dout"}, dout, exp_dout);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    function automatic int model(input logic [7:0] data, input logic par,
                                 input logic stop, input bit en);
        int ones;
        if (!en) return 0;
        if (!stop) return 3;
        ones = par;
        for (int b = 0; b < 8; b++) ones += data[b];
        return (ones % 2 == 1) ? 1 : 2;
    endfunction

    initial begin
        int         kind;
        logic [7:0] data;
        logic       par, stop;
        int         mode;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.dout", dout, 8'h00);
        check("rst.pulses", {rx_done, parity_err, frame_err}, 3'b000);
        check("rst.busy", busy, 1'b0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // 0x1C good frame
        snap();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
        kind = model(8'h1C, 1'b0, 1'b1, 1'b1);
        if (kind == 1) exp_dout = 8'h1C;
        expect_outcome("f1C", kind);

        // 0xF0 with wrong parity
        snap();
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 0, 10, 1'b0);
        expect_outcome("fF0_perr", 2);

        // 0x1C with stop = 0
        snap();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 0, 10, 1'b0);
        expect_outcome("f1C_stop0", 3);

        // Clock halted after 5 bits
        snap();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 4, 1'b0);
        check("timeout.busy_mid", busy, 1'b1);
        repeat (TIMEOUT + 50) @(negedge clk);
        expect_outcome("timeout", 3);
        snap();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 0, 10, 1'b0);
        exp_dout = 8'h1C;
        expect_outcome("after_timeout", 1);

        // Short glitches in IDLE and mid-frame are rejected
        snap();
        glitch();
        check("glitch_idle.busy", busy, 1'b0);
        send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 0, 4, 1'b0);
        ps2d = 1'b0;
        glitch();
        send_bits(mk_frame(8'h5A, 1'b1, 1'b1), 5, 10, 1'b0);
        exp_dout = 8'h5A;
        expect_outcome("glitch", 1);

        // Reset mid-frame, then 0xF0 with good parity
        snap();
        send_bits(mk_frame(8'h33, 1'b1, 1'b1), 0, 4, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst.dout", dout, 8'h00);
        check("midrst.busy", busy, 1'b0);
        rst = 1'b1;
        exp_dout = 8'h00;
        expect_outcome("midrst", 0);
        snap();
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 0, 10, 1'b0);
        exp_dout = 8'hF0;
        expect_outcome("fF0_good", 1);

        // Randomized frames, including rx_en held low or dropped after the start bit
        for (int n = 0; n < 16; n++) begin
            data = 8'($urandom);
            par  = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            mode = $urandom_range(0, 3);
            snap();
            rx_en = (mode != 0);
            send_bits(mk_frame(data, par, stop), 0, 10, mode == 1);
            kind = model(data, par, stop, mode != 0);
            if (kind == 1) exp_dout = data;
            expect_outcome($sformatf("rnd%0d", n), kind);
            rx_en = 1'b1;
        end

        check("latency", lat_bad, 0);
        check("exclusive", excl_bad, 0);
        check("dout_stable", dout_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
